// File: rtl/axi4lite_cmd_master.sv
// Simple-command to AXI4-Lite master bridge.
//
// Accepts one read or write command at a time on a valid/ready command port,
// runs it as a single AXI4-Lite transaction and returns the response on a
// valid/ready response port. At most one transaction is outstanding.
//
// Ports:
//   s_axi_aclk, s_axi_areset   clock, synchronous active-high reset
//   cmd_*                      command: write flag, byte address, data, strobes
//   rsp_*                      response: write echo, read data, resp, timeout flag
//   m_axi_aw*/w*/b*/ar*/r*     AXI4-Lite master channels
//
// Optional feature (macro AXI4LITE_CMD_MASTER_TIMEOUT_EN): a watchdog aborts a
// transaction that spends TIMEOUT_CYCLES in any single AXI wait state. The
// abort drops valids/readies before their handshake, which breaks AXI rules;
// it exists only so a bench cannot hang on a dead slave. Without the macro no
// counter exists, rsp_timeout is tied 0 and the bridge waits indefinitely.
module axi4lite_cmd_master #(
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                s_axi_aclk,
  input  logic                s_axi_areset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam int unsigned StrbW = DATA_W / 8;

  if (TIMEOUT_CYCLES == 0 || DATA_W % 8 != 0) begin : g_bad_cfg
    $error("axi4lite_cmd_master: TIMEOUT_CYCLES must be > 0 and DATA_W a multiple of 8");
  end

  typedef enum logic [2:0] {StIdle, StWrAwW, StWrB, StRdAr, StRdR, StRsp} state_e;

  state_e              state_q, state_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                cmd_ready_q, awvalid_q, wvalid_q, bready_q;
  logic                arvalid_q, rready_q, rsp_valid_q;

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic            tmo_abort;
`endif

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? StWrAwW : StRdAr;
        end
      end
      StWrAwW: begin
        if (awvalid_q && m_axi_awready) aw_done_d = 1'b1;
        if (wvalid_q && m_axi_wready)   w_done_d  = 1'b1;
        // Leave on the registered flags, so B is only opened once both
        // address and data have been seen as done for a full cycle.
        if (aw_done_q && w_done_q) state_d = StWrB;
      end
      StWrB: begin
        if (m_axi_bvalid && bready_q) begin
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          state_d     = StRsp;
        end
      end
      StRdAr: begin
        if (arvalid_q && m_axi_arready) state_d = StRdR;
      end
      StRdR: begin
        if (m_axi_rvalid && rready_q) begin
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_valid_q && rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
    tmo_abort     = 1'b0;
    tmo_cnt_d     = '0;
    rsp_timeout_d = rsp_timeout_q;
    // Count only while parked in an AXI wait state; any state change clears.
    if (state_q != StIdle && state_q != StRsp && state_d == state_q) begin
      if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        tmo_abort   = 1'b1;
        state_d     = StRsp;
        rsp_write_d = (state_q == StWrAwW) || (state_q == StWrB);
        rsp_rdata_d = '0;
        rsp_resp_d  = 2'b10;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TmoW'(1);
      end
    end
    if (state_q != StRsp && state_d == StRsp) rsp_timeout_d = tmo_abort;
`endif
  end

  // Every handshake-visible output is registered from the next state.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cmd_ready_q <= (state_d == StIdle);
      awvalid_q   <= (state_d == StWrAwW) && !aw_done_d;
      wvalid_q    <= (state_d == StWrAwW) && !w_done_d;
      bready_q    <= (state_d == StWrB);
      arvalid_q   <= (state_d == StRdAr);
      rready_q    <= (state_d == StRdR);
      rsp_valid_q <= (state_d == StRsp);
    end
  end

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_cmd_master.sv
// Bench for axi4lite_cmd_master: directed vector table, hand sequences for
// response back-pressure, reset mid-transaction and (with the timeout macro)
// a dead slave, then randomized commands against a latency/response model.
module tb_axi4lite_cmd_master;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [DW-1:0] m_axi_wdata;
  logic [SW-1:0] m_axi_wstrb;
  logic          m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic          m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid;
  logic [1:0]    m_axi_bresp, m_axi_rresp;
  logic [DW-1:0] m_axi_rdata;

  axi4lite_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Slave configuration: cycles of valid seen before ready, and B/R latency.
  int         aw_d = 0, w_d = 0, b_d = 0, ar_d = 0, r_d = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;

  // Slave state and cumulative statistics (written only by the slave loop).
  int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit   have_aw, have_w, have_ar;
  bit   aw_fire, w_fire, ar_fire, b_fire, r_fire;
  bit   pv_aw, pv_w, pv_ar;
  logic [AW-1:0] pa_aw, pa_ar, got_awaddr, got_araddr;
  logic [DW-1:0] pd_w, got_wdata;
  logic [SW-1:0] ps_w, got_wstrb;
  int   n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  int   hi_aw = 0, hi_w = 0, hi_ar = 0;

  // Slave and protocol monitor, acting on the falling edge. Fire flags hold
  // the handshakes that the following rising edge will complete.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        have_aw = 0; have_w = 0; have_ar = 0;
        aw_fire = 0; w_fire = 0; ar_fire = 0; b_fire = 0; r_fire = 0;
        pv_aw = 0; pv_w = 0; pv_ar = 0;
      end else begin
        if (pv_aw && !aw_fire) check("aw_hold", 64'({m_axi_awvalid, m_axi_awaddr}), 64'({1'b1, pa_aw}));
        if (pv_w && !w_fire) check("w_hold", 64'({m_axi_wvalid, m_axi_wdata, m_axi_wstrb}),
                                   64'({1'b1, pd_w, ps_w}));
        if (pv_ar && !ar_fire) check("ar_hold", 64'({m_axi_arvalid, m_axi_araddr}), 64'({1'b1, pa_ar}));
        if (aw_fire) begin n_aw++; have_aw = 1; end
        if (w_fire)  begin n_w++;  have_w  = 1; end
        if (ar_fire) begin n_ar++; have_ar = 1; end
        if (b_fire)  begin n_b++;  m_axi_bvalid = 0; end
        if (r_fire)  begin n_r++;  m_axi_rvalid = 0; end
        if (have_aw && have_w && !m_axi_bvalid) begin
          if (b_cnt >= b_d) begin
            m_axi_bvalid = 1; m_axi_bresp = cfg_bresp; have_aw = 0; have_w = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (have_ar && !m_axi_rvalid) begin
          if (r_cnt >= r_d) begin
            m_axi_rvalid = 1; m_axi_rresp = cfg_rresp; m_axi_rdata = cfg_rdata;
            have_ar = 0; r_cnt = 0;
          end else r_cnt++;
        end
        if (m_axi_awvalid) begin hi_aw++; m_axi_awready = (aw_cnt >= aw_d); aw_cnt++; end
        else begin m_axi_awready = 0; aw_cnt = 0; end
        if (m_axi_wvalid) begin hi_w++; m_axi_wready = (w_cnt >= w_d); w_cnt++; end
        else begin m_axi_wready = 0; w_cnt = 0; end
        if (m_axi_arvalid) begin hi_ar++; m_axi_arready = (ar_cnt >= ar_d); ar_cnt++; end
        else begin m_axi_arready = 0; ar_cnt = 0; end
        aw_fire = m_axi_awvalid && m_axi_awready;
        w_fire  = m_axi_wvalid && m_axi_wready;
        ar_fire = m_axi_arvalid && m_axi_arready;
        b_fire  = m_axi_bvalid && m_axi_bready;
        r_fire  = m_axi_rvalid && m_axi_rready;
        if (aw_fire) got_awaddr = m_axi_awaddr;
        if (w_fire)  begin got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb; end
        if (ar_fire) got_araddr = m_axi_araddr;
        pv_aw = m_axi_awvalid; pa_aw = m_axi_awaddr;
        pv_w  = m_axi_wvalid;  pd_w  = m_axi_wdata; ps_w = m_axi_wstrb;
        pv_ar = m_axi_arvalid; pa_ar = m_axi_araddr;
      end
    end
  end

  // Reference: cycles from command handshake to the first rsp_valid cycle.
  // Write: AW/W rise on cycle 1, the later one completes on cycle L; B opens
  // two cycles later and the slave's B appears bd+1 cycles after L.
  function automatic int model_lat(bit wr, int awd, int wd, int bd, int ard, int rd);
    int last;
    if (wr) begin
      last = 1 + ((awd > wd) ? awd : wd);
      return (bd > 1) ? last + 2 + bd : last + 3;
    end
    return 3 + ard + rd;
  endfunction

  // Issue one command (called on a falling edge) and check everything about it.
  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] wstrb, input int hold, input int exp_lat,
                         input logic [DW-1:0] exp_rdata, input logic [1:0] exp_resp);
    int s_aw, s_w, s_b, s_ar, s_r, s_haw, s_hw, s_har, k, lat;
    s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_r = n_r;
    s_haw = hi_aw; s_hw = hi_w; s_har = hi_ar;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = wstrb; cmd_valid = 1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
    check("cmd_accept", 64'(cmd_ready), 64'(1));
    @(negedge clk);
    cmd_valid = 0; cmd_addr = AW'($urandom); cmd_wdata = $urandom; cmd_wstrb = SW'($urandom);
    check("valid_cycle1", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}),
          wr ? 64'(3'b110) : 64'(3'b001));
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_fields", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout}),
          64'({1'b1, wr, exp_rdata, exp_resp, 1'b0}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("rsp_hold", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, cmd_ready}),
            64'({1'b1, wr, exp_rdata, exp_resp, 1'b0, 1'b0}));
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    check("rsp_done", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    check("hs_count", 64'({4'(n_aw - s_aw), 4'(n_w - s_w), 4'(n_b - s_b), 4'(n_ar - s_ar),
                           4'(n_r - s_r)}), wr ? 64'(20'h11100) : 64'(20'h00011));
    check("valid_cycles", 64'({8'(hi_aw - s_haw), 8'(hi_w - s_hw), 8'(hi_ar - s_har)}),
          wr ? 64'({8'(aw_d + 1), 8'(w_d + 1), 8'd0}) : 64'({8'd0, 8'd0, 8'(ar_d + 1)}));
    if (wr) check("wr_payload", 64'({got_awaddr, got_wdata, got_wstrb}), 64'({addr, wdata, wstrb}));
    else    check("rd_payload", 64'(got_araddr), 64'(addr));
  endtask

  typedef struct {
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd, wd, bd, ard, rd, hold;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 5'h08, 32'h0000_0001, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 4, 32'h0};
    vecs[1] = '{1'b1, 5'h0C, 32'hDEAD_BEEF, 4'h3, 3, 0, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFFF, 7, 32'h0};
    vecs[2] = '{1'b0, 5'h00, 32'h0, 4'h0, 0, 0, 0, 0, 2, 0, 2'b00, 32'hA5A5_5A5A, 5, 32'hA5A5_5A5A};
    vecs[3] = '{1'b0, 5'h10, 32'h0, 4'h0, 0, 0, 0, 0, 0, 5, 2'b10, 32'h0000_1234, 3, 32'h0000_1234};
    vecs[4] = '{1'b1, 5'h1C, 32'h1234_5678, 4'h5, 0, 2, 3, 0, 0, 1, 2'b11, 32'h0, 8, 32'h0};
    vecs[5] = '{1'b0, 5'h04, 32'h0, 4'h0, 0, 0, 0, 2, 1, 0, 2'b01, 32'hFFFF_0000, 6, 32'hFFFF_0000};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                             m_axi_rready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout}),
          64'(0));
    check("reset_data", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}), 64'(0));
    rst = 0;
    @(negedge clk);
    check("idle_ready", 64'(cmd_ready), 64'(1));

    // Directed table.
    foreach (vecs[i]) begin
      aw_d = vecs[i].awd; w_d = vecs[i].wd; b_d = vecs[i].bd; ar_d = vecs[i].ard; r_d = vecs[i].rd;
      cfg_bresp = vecs[i].resp; cfg_rresp = vecs[i].resp; cfg_rdata = vecs[i].rdata;
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].hold,
              vecs[i].lat, vecs[i].exp_rdata, vecs[i].resp);
    end

    // Reset while AW is waiting: everything clears, no response follows.
    aw_d = 20; w_d = 0; b_d = 0; ar_d = 0; r_d = 0;
    cmd_write = 1; cmd_addr = 5'h14; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    check("pre_rst_awvalid", 64'(m_axi_awvalid), 64'(1));
    rst = 1;
    @(negedge clk);
    check("midrst_ctrl", 64'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                              m_axi_rready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout}),
          64'(0));
    check("midrst_data", 64'({m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_wstrb}), 64'(0));
    @(negedge clk);
    rst = 0;
    aw_d = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'({rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                   m_axi_arvalid, m_axi_rready}), 64'(0));
    end
    check("post_rst_ready", 64'(cmd_ready), 64'(1));
    cfg_bresp = 2'b00;
    run_cmd(1'b1, 5'h08, 32'h0000_0001, 4'hF, 0, 4, 32'h0, 2'b00);

`ifdef AXI4LITE_CMD_MASTER_TIMEOUT_EN
    begin
      int ar_hi, lat;
      ar_d = 100000;
      cmd_write = 0; cmd_addr = 5'h18; cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
      ar_hi = 0; lat = 1;
      while (!rsp_valid && lat < 100) begin
        if (m_axi_arvalid) ar_hi++;
        @(negedge clk);
        lat++;
      end
      check("tmo_ar_cycles", 64'(ar_hi), 64'(16));
      check("tmo_latency", 64'(lat), 64'(17));
      check("tmo_rsp", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout, m_axi_arvalid}),
            64'({1'b1, 1'b0, 32'h0, 2'b10, 1'b1, 1'b0}));
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      ar_d = 0;
      check("tmo_recover", 64'({rsp_valid, cmd_ready}), 64'(2'b01));
    end
`endif

    // Randomized commands against the reference model.
    for (int t = 0; t < 40; t++) begin
      bit          wr;
      logic [31:0] rd;
      logic [1:0]  rs;
      int          hold;
      wr = 1'($urandom_range(0, 1));
      aw_d = $urandom_range(0, 3); w_d = $urandom_range(0, 3); b_d = $urandom_range(0, 3);
      ar_d = $urandom_range(0, 3); r_d = $urandom_range(0, 3);
      rd = $urandom; rs = 2'($urandom); hold = $urandom_range(0, 2);
      cfg_bresp = rs; cfg_rresp = rs; cfg_rdata = rd;
      run_cmd(wr, AW'($urandom), $urandom, SW'($urandom), hold,
              model_lat(wr, aw_d, w_d, b_d, ar_d, r_d), wr ? 32'h0 : rd, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "bench watchdog expired");
  end

endmodule
